// File: rtl/step_diff_counter.sv
// step_diff_counter: two step-driven counters (A and B) whose registered
// difference (cnt_b - cnt_a) is streamed out over a valid/ready port.
// A small IDLE/RUN/DRAIN FSM governs when the counters advance and lets a
// pending result drain after stop before returning to IDLE.
module step_diff_counter #(
  parameter int WIDTH = 6,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] step_a,
  input  logic [WIDTH-1:0] step_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [WIDTH-1:0] cnt_a,
  output logic [WIDTH-1:0] cnt_b,
  output logic             ovf_a,
  output logic             ovf_b,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Output handshake: a result (diff, borrow) is presented while out_valid
  // is high and is consumed on any rising edge where out_valid and
  // out_ready are both high. Once raised, out_valid and the result hold
  // until that transfer; a new advance may refill the slot on the very
  // edge that transfers the old result.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             clear;
  logic             advance;
  logic             xfer;
  logic [WIDTH:0]   sum_a;
  logic [WIDTH:0]   sum_b;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;

  // Next-state logic plus the clear/advance strobes for the datapath.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    advance   = 1'b0;
    xfer      = out_valid && out_ready;
    case (state)
      IDLE: begin
        // stop beats start when both arrive together
        if (start && !stop) begin
          clear     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // a result still waiting on the consumer must drain first
          if (out_valid && !out_ready) state_nxt = DRAIN;
          else                         state_nxt = IDLE;
        end else if (!out_valid || out_ready) begin
          advance = 1'b1;
        end
      end
      DRAIN: begin
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter adders; the extra MSB is the carry that sets the sticky flag.
  always_comb begin
    sum_a = {1'b0, cnt_a} + {1'b0, step_a};
    sum_b = {1'b0, cnt_b} + {1'b0, step_b};
    nxt_a = (SAT && sum_a[WIDTH]) ? {WIDTH{1'b1}} : sum_a[WIDTH-1:0];
    nxt_b = (SAT && sum_b[WIDTH]) ? {WIDTH{1'b1}} : sum_b[WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Valid flag: set by an advance, cleared by a transfer without refill.
  always_ff @(posedge clk) begin
    if (rst)          out_valid <= 1'b0;
    else if (advance) out_valid <= 1'b1;
    else if (xfer)    out_valid <= 1'b0;
  end

  // Counters, overflow flags and the registered difference result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a  <= '0;
      cnt_b  <= '0;
      ovf_a  <= 1'b0;
      ovf_b  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (clear) begin
      cnt_a  <= '0;
      cnt_b  <= '0;
      ovf_a  <= 1'b0;
      ovf_b  <= 1'b0;
    end else if (advance) begin
      // difference always wraps and uses the pre-advance counter values
      diff   <= cnt_b - cnt_a;
      borrow <= (cnt_b < cnt_a);
      cnt_a  <= nxt_a;
      cnt_b  <= nxt_b;
      ovf_a  <= ovf_a | sum_a[WIDTH];
      ovf_b  <= ovf_b | sum_b[WIDTH];
    end
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_step_diff_counter.sv
// Bench for step_diff_counter: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share one stimulus stream; directed vectors plus a small
// counter model and a transfer scoreboard supply the expected values.
module tb_step_diff_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [5:0] step_a;
  logic [5:0] step_b;
  logic       out_ready;

  logic       w_out_valid, s_out_valid;
  logic [5:0] w_diff, s_diff;
  logic       w_borrow, s_borrow;
  logic [5:0] w_cnt_a, s_cnt_a;
  logic [5:0] w_cnt_b, s_cnt_b;
  logic       w_ovf_a, s_ovf_a;
  logic       w_ovf_b, s_ovf_b;
  logic       w_busy, s_busy;
  logic [1:0] w_state, s_state;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entry: {s_borrow, s_diff, w_borrow, w_diff}
  logic [13:0] exp_q[$];
  logic [13:0] sb_e;

  // counter model: ma shared, mb wrapping B, ms saturating B
  logic [5:0] ma, mb, ms;
  logic       oa, ob, os;
  logic [5:0] ld, ls;

  step_diff_counter #(.WIDTH(6), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step_a(step_a), .step_b(step_b), .out_ready(out_ready),
    .out_valid(w_out_valid), .diff(w_diff), .borrow(w_borrow),
    .cnt_a(w_cnt_a), .cnt_b(w_cnt_b), .ovf_a(w_ovf_a), .ovf_b(w_ovf_b),
    .busy(w_busy), .state_dbg(w_state)
  );

  step_diff_counter #(.WIDTH(6), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step_a(step_a), .step_b(step_b), .out_ready(out_ready),
    .out_valid(s_out_valid), .diff(s_diff), .borrow(s_borrow),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .ovf_a(s_ovf_a), .ovf_b(s_ovf_b),
    .busy(s_busy), .state_dbg(s_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    ma = 6'd0; mb = 6'd0; ms = 6'd0;
    oa = 1'b0; ob = 1'b0; os = 1'b0;
  endtask

  // one expected advance: queue the result, then step the model counters
  task automatic model_adv();
    logic [6:0] sa, sb, ss;
    ld = mb - ma;
    ls = ms - ma;
    exp_q.push_back({(ms < ma), ls, (mb < ma), ld});
    sa = {1'b0, ma} + {1'b0, step_a};
    sb = {1'b0, mb} + {1'b0, step_b};
    ss = {1'b0, ms} + {1'b0, step_b};
    ma = sa[5:0];
    mb = sb[5:0];
    ms = ss[6] ? 6'h3f : ss[5:0];
    oa = oa | sa[6];
    ob = ob | sb[6];
    os = os | ss[6];
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_w_cnt_a"}, w_cnt_a, ma);
    check({tag, "_w_cnt_b"}, w_cnt_b, mb);
    check({tag, "_s_cnt_a"}, s_cnt_a, ma);
    check({tag, "_s_cnt_b"}, s_cnt_b, ms);
    check({tag, "_w_ovf_a"}, w_ovf_a, oa);
    check({tag, "_w_ovf_b"}, w_ovf_b, ob);
    check({tag, "_s_ovf_b"}, s_ovf_b, os);
  endtask

  // scoreboard: a transfer happens at the next rising edge whenever
  // valid and ready are both high now (reset overrides)
  always @(negedge clk) begin
    if (!rst && w_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check("xfer_w_diff", w_diff, sb_e[5:0]);
        check("xfer_w_borrow", w_borrow, sb_e[6]);
        check("xfer_s_diff", s_diff, sb_e[12:7]);
        check("xfer_s_borrow", s_borrow, sb_e[13]);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    step_a = 6'd0; step_b = 6'd0; out_ready = 1'b0;
    model_clear();
    tick();
    tick();
    check("rst_valid", w_out_valid, 0);
    check("rst_busy", w_busy, 0);
    check("rst_state", w_state, 0);
    check("rst_diff", w_diff, 0);
    check_cnt("rst");

    // streaming run, step_a=1, step_b=5
    rst = 1'b0; step_a = 6'd1; step_b = 6'd5; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", w_state, 1);
    check("start_busy", w_busy, 1);
    check("start_valid", w_out_valid, 0);
    check_cnt("start");
    for (int k = 1; k <= 14; k++) begin
      tick();
      model_adv();
      check("run_valid", w_out_valid, 1);
      check("run_s_valid", s_out_valid, 1);
      check_cnt("run");
    end
    // hand-derived anchor values after the 14th advance
    check("run14_w_diff", w_diff, 52);
    check("run14_w_borrow", w_borrow, 1);
    check("run14_s_diff", s_diff, 50);
    check("run14_s_borrow", s_borrow, 0);
    check("run14_s_cnt_b", s_cnt_b, 63);
    check("run14_w_cnt_b", w_cnt_b, 6);

    // back-pressure: five stalled cycles
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", w_out_valid, 1);
      check("stall_w_diff", w_diff, ld);
      check("stall_s_diff", s_diff, ls);
      check_cnt("stall");
    end
    out_ready = 1'b1;
    tick();
    model_adv();
    check_cnt("resume");

    // stop while the result is unaccepted -> DRAIN
    out_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    check("drain_state", w_state, 2);
    check("drain_busy", w_busy, 1);
    check("drain_valid", w_out_valid, 1);
    check_cnt("drain");
    tick();
    start = 1'b0;
    check("drain_hold_state", w_state, 2);
    check_cnt("drain_hold");
    out_ready = 1'b1;
    tick();
    check("drained_state", w_state, 0);
    check("drained_valid", w_out_valid, 0);
    check("drained_busy", w_busy, 0);
    check_cnt("drained");

    // restart, force B overflow, then reset mid-run
    step_a = 6'd2; step_b = 6'd63;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_cnt("restart");
    tick();
    model_adv();
    tick();
    model_adv();
    check_cnt("ovf");
    check("ovf_w_b_set", w_ovf_b, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    exp_q.delete();
    model_clear();
    rst = 1'b0; start = 1'b1; stop = 1'b1;
    check("midrst_state", w_state, 0);
    check("midrst_valid", w_out_valid, 0);
    check("midrst_diff", w_diff, 0);
    check("midrst_borrow", w_borrow, 0);
    check("midrst_s_valid", s_out_valid, 0);
    check_cnt("midrst");
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_state", w_state, 0);
    check("startstop_busy", w_busy, 0);
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_diff_counter.md
STEP_DIFF_COUNTER -- requirements
Module: step_diff_counter

Interface
REQ-001 Parameter WIDTH, default 6: width of the counters, steps and difference.
REQ-002 Parameter SAT, default 0: overflow mode; 0 = wrap modulo 2^WIDTH, 1 = saturate at 2^WIDTH-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to clear the counters and begin counting.
REQ-006 stop  input  1  one-cycle request to end counting.
REQ-007 step_a  input  WIDTH  increment for counter A, sampled on every advance.
REQ-008 step_b  input  WIDTH  increment for counter B, sampled on every advance.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_valid  output  1  diff/borrow hold an unaccepted result.
REQ-011 diff  output  WIDTH  registered (cnt_b - cnt_a) mod 2^WIDTH.
REQ-012 borrow  output  1  registered, 1 when cnt_b < cnt_a (unsigned) at sampling.
REQ-013 cnt_a, cnt_b  output  WIDTH each  current counter values.
REQ-014 ovf_a, ovf_b  output  1 each  sticky overflow flags.
REQ-015 busy  output  1  high in RUN or DRAIN.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DRAIN; reset state SHALL be IDLE.
REQ-017 Advance condition SHALL be: state RUN, stop low, and (out_valid low or out_ready high).
REQ-018 On an advance: diff <= cnt_b - cnt_a and borrow <= (cnt_b < cnt_a), both using pre-advance counter values; out_valid <= 1; cnt_a += step_a; cnt_b += step_b.
REQ-019 Transfer SHALL occur on any edge with out_valid and out_ready both high; out_valid SHALL fall after a transfer unless the same edge performs an advance.
REQ-020 When out_valid is high and out_ready is low, diff, borrow, cnt_a and cnt_b SHALL hold (back-pressure stall).
REQ-021 In IDLE, start high with stop low: cnt_a, cnt_b, ovf_a and ovf_b cleared to 0, next state RUN; out_valid unaffected; no advance on that edge.
REQ-022 start SHALL be ignored in RUN and DRAIN; with start and stop high together in IDLE, stop wins and the state stays IDLE.
REQ-023 stop in RUN: if out_valid is high and out_ready is low, go to DRAIN, otherwise go to IDLE; no advance on that edge.
REQ-024 DRAIN: counters hold; on transfer go to IDLE; start and stop ignored.
REQ-025 Carry out of a counter add SHALL set its ovf flag, which stays set until start or rst.
REQ-026 SAT=0: counter takes the sum mod 2^WIDTH. SAT=1: on carry the counter becomes 2^WIDTH-1 and stays there.
REQ-027 Step changes SHALL take effect at the next advance; a step of 0 holds its counter while results still stream.
REQ-028 diff arithmetic SHALL always wrap modulo 2^WIDTH, regardless of SAT.

Reset
REQ-029 rst high at any edge, including mid-RUN, DRAIN or stall: state IDLE; out_valid, diff, borrow, cnt_a, cnt_b, ovf_a and ovf_b all 0.
REQ-030 rst SHALL take priority over start, stop and out_ready on the same edge.

Verification
REQ-031 WIDTH=6, SAT=0, step_a=1, step_b=5, out_ready=1, pulse start: transfer k gives diff=4(k-1), borrow=0 for k=1..13.
REQ-032 Same run continued: ovf_b=1 after the 13th advance (cnt_b=1, cnt_a=13); transfer 14 gives diff=52, borrow=1; ovf_a stays 0.
REQ-033 Same stimulus with SAT=1: cnt_b=63 from the 13th advance on, ovf_b=1; transfer 14 gives diff=50, borrow=0.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles while out_valid=1 -> diff, cnt_a and cnt_b are constant; on release, counting resumes with no value skipped or duplicated.
REQ-035 stop with out_valid=1 and out_ready=0 -> DRAIN with busy=1 and counters held; raise out_ready -> one transfer, then IDLE, out_valid=0, busy=0.
REQ-036 rst asserted mid-RUN with ovf_b=1 -> all outputs 0 on the next edge; start and stop high together in IDLE -> remains IDLE.
